// File: rtl/fft_pkg.sv
// Shared definitions for the R2SDF butterfly stage: width helpers, complex sample type, phase codes.
// FFT_SCALE_EN selects the 1/2-per-stage scaled datapath (OW = W) instead of full growth (OW = W+1).
package fft_pkg;

    typedef enum logic {
        PH_FILL = 1'b0,
        PH_BFLY = 1'b1
    } phase_e;

    function automatic int unsigned calc_w(input int unsigned n);
        return 32'd1 << n;
    endfunction

    function automatic int unsigned calc_ow(input int unsigned n);
`ifdef FFT_SCALE_EN
        return calc_w(n);
`else
        return calc_w(n) + 32'd1;
`endif
    endfunction

    localparam int unsigned DEF_N  = 3;
    localparam int unsigned DEF_OW = calc_ow(DEF_N);

    // Complex sample at the default configuration; parameterised stages build their own.
    typedef struct packed {
        logic signed [DEF_OW-1:0] re;
        logic signed [DEF_OW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_sdf_delay_line.sv
// Feedback delay memory for one SDF stage: single address, read-before-write, storage not reset.
module sdf_delay_line #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned WIDTH      = 18
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    // Combinational read returns the old word; the write lands on the clock edge.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/fft_sdf_stage.sv
// Streaming radix-2 single-path delay-feedback butterfly stage with a one-deep output register.
// Build with FFT_SCALE_EN defined for floor(x/2) scaling of every sum and difference.
module fft_sdf_stage
    import fft_pkg::*;
#(
    parameter int unsigned N          = 3,
    parameter int unsigned LOG2_DELAY = 2,
    localparam int unsigned W         = calc_w(N),
    localparam int unsigned OW        = calc_ow(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [W-1:0]  in_r,
    input  logic [W-1:0]  in_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sof,
    output logic [OW-1:0] out_r,
    output logic [OW-1:0] out_i,
    output logic          sync_err
);

    localparam int unsigned D  = 32'd1 << LOG2_DELAY;
    localparam int unsigned CW = LOG2_DELAY + 1;
    localparam int unsigned XW = OW + 1;

    typedef struct packed {
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
    } sample_t;

    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  primed, primed_nxt;
    logic                  out_valid_nxt, out_sof_nxt, sync_err_nxt;
    logic [OW-1:0]         out_r_nxt, out_i_nxt;
    logic                  step, resync, we;
    logic [LOG2_DELAY-1:0] addr;
    phase_e                phase;
    sample_t               in_s, rd, wr;
    logic signed [XW-1:0]  sum_r, sum_i, dif_r, dif_i;

    function automatic logic [OW-1:0] scale(input logic signed [XW-1:0] x);
`ifdef FFT_SCALE_EN
        return OW'(x >>> 1);
`else
        return OW'(x);
`endif
    endfunction

    assign in_ready = out_ready | ~out_valid;
    assign step     = in_valid & in_ready;
    assign resync   = step & in_sof & (cnt != '0);

    // A resync sample is handled as index 0 of a fresh frame.
    assign addr  = resync ? '0 : cnt[LOG2_DELAY-1:0];
    assign phase = resync ? PH_FILL : phase_e'(cnt[CW-1]);

    assign in_s.re = OW'($signed(in_r));
    assign in_s.im = OW'($signed(in_i));

    assign sum_r = XW'($signed(rd.re)) + XW'($signed(in_s.re));
    assign sum_i = XW'($signed(rd.im)) + XW'($signed(in_s.im));
    assign dif_r = XW'($signed(rd.re)) - XW'($signed(in_s.re));
    assign dif_i = XW'($signed(rd.im)) - XW'($signed(in_s.im));

    sdf_delay_line #(
        .DEPTH_LOG2(LOG2_DELAY),
        .WIDTH     (2 * OW)
    ) u_delay (
        .clk  (clk),
        .we   (we),
        .addr (addr),
        .wdata(wr),
        .rdata(rd)
    );

    always_comb begin
        cnt_nxt       = cnt;
        primed_nxt    = primed;
        out_valid_nxt = out_valid & ~out_ready;
        out_sof_nxt   = out_sof & out_valid & ~out_ready;
        out_r_nxt     = out_r;
        out_i_nxt     = out_i;
        sync_err_nxt  = sync_err;
        we            = 1'b0;
        wr            = in_s;
        if (step) begin
            we          = 1'b1;
            cnt_nxt     = cnt + CW'(1);
            out_sof_nxt = 1'b0;
            if (resync) begin
                cnt_nxt       = CW'(1);
                primed_nxt    = 1'b0;
                out_valid_nxt = 1'b0;
                sync_err_nxt  = 1'b1;
            end else if (phase == PH_FILL) begin
                // Drain the previous frame's difference while storing the new sample.
                out_valid_nxt = primed;
                if (primed) begin
                    out_r_nxt = rd.re;
                    out_i_nxt = rd.im;
                end
            end else begin
                wr.re         = scale(dif_r);
                wr.im         = scale(dif_i);
                out_valid_nxt = 1'b1;
                out_r_nxt     = scale(sum_r);
                out_i_nxt     = scale(sum_i);
                out_sof_nxt   = (cnt == CW'(D));
                if (cnt == '1) begin
                    primed_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            sync_err  <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            primed    <= primed_nxt;
            out_valid <= out_valid_nxt;
            out_sof   <= out_sof_nxt;
            out_r     <= out_r_nxt;
            out_i     <= out_i_nxt;
            sync_err  <= sync_err_nxt;
        end
    end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Self-checking bench for fft_sdf_stage (N=3, D=4) against a frame-level butterfly model.
`timescale 1ns/1ps
module tb_fft_sdf_stage;
    import fft_pkg::*;

    localparam int unsigned N          = 3;
    localparam int unsigned LOG2_DELAY = 2;
    localparam int unsigned W          = calc_w(N);
    localparam int unsigned OW         = calc_ow(N);
    localparam int D     = 4;
    localparam int LIMIT = 600;
`ifdef FFT_SCALE_EN
    localparam int S0 = 3, S1 = 4, S2 = 5, S3 = 6, DF = -2, XDIF = -128;
`else
    localparam int S0 = 6, S1 = 8, S2 = 10, S3 = 12, DF = -4, XDIF = -255;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_sof, sync_err;
    logic [W-1:0] in_r = '0, in_i = '0;
    logic signed [OW-1:0] out_r, out_i;

    always #5 clk = ~clk;

    fft_sdf_stage #(.N(N), .LOG2_DELAY(LOG2_DELAY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_r(in_r), .in_i(in_i), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_r(out_r), .out_i(out_i),
        .sync_err(sync_err)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        int r;
        int i;
        bit sof;
    } exp_t;

    exp_t exp_q[$];
    int   fr_r[2*D], fr_i[2*D], df_r[D], df_i[D];
    int   idx;
    bit   have_diff;
    bit   exp_sync;
    int   stim_r[$], stim_i[$];
    bit   stim_s[$];
    bit   obs_take, obs_rdy, obs_val, obs_sof;
    int   obs_r, obs_i;

    function automatic int sc(input int x);
`ifdef FFT_SCALE_EN
        return x >>> 1;
`else
        return x;
`endif
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        idx = 0;
        have_diff = 0;
        exp_sync = 0;
    endfunction

    // Frame-level R2SDF behaviour: sums leave as soon as x[k+D] arrives, differences wait for the next frame.
    function automatic void model_accept(input int r, input int i, input bit sof);
        exp_t e;
        if (sof && idx != 0) begin
            exp_sync = 1;
            have_diff = 0;
            idx = 0;
        end
        fr_r[idx] = r;
        fr_i[idx] = i;
        if (idx < D) begin
            if (have_diff) begin
                e.r = df_r[idx]; e.i = df_i[idx]; e.sof = 0;
                exp_q.push_back(e);
            end
        end else begin
            e.r = sc(fr_r[idx-D] + r); e.i = sc(fr_i[idx-D] + i); e.sof = (idx == D);
            exp_q.push_back(e);
        end
        idx++;
        if (idx == 2*D) begin
            for (int k = 0; k < D; k++) begin
                df_r[k] = sc(fr_r[k] - fr_r[k+D]);
                df_i[k] = sc(fr_i[k] - fr_i[k+D]);
            end
            have_diff = 1;
            idx = 0;
        end
    endfunction

    function automatic void add_sample(input int r, input int i, input bit s);
        stim_r.push_back(r);
        stim_i.push_back(i);
        stim_s.push_back(s);
    endfunction

    function automatic void clear_stim();
        stim_r.delete();
        stim_i.delete();
        stim_s.delete();
    endfunction

    // Drive one cycle at the falling edge, then capture what the coming rising edge will see.
    task automatic drive(input bit v, input bit sof, input int r, input int i, input bit ordy);
        @(negedge clk);
        in_valid = v; in_sof = sof; in_r = W'(r); in_i = W'(i); out_ready = ordy;
        #1;
        obs_rdy = in_ready;
        obs_val = out_valid;
        obs_take = out_valid & ordy;
        obs_r = int'(out_r);
        obs_i = int'(out_i);
        obs_sof = out_sof;
        if (v && in_ready) model_accept(r, i, sof);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; in_sof = 0; out_ready = 1; rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        in_valid = 0; in_sof = 0; out_ready = 1;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
        total++; if (out_sof !== 1'b0) begin bad++; $display("FAIL reset_out_sof: got %0b, required 0", out_sof); end
        total++; if (out_r !== '0 || out_i !== '0) begin bad++; $display("FAIL reset_data: got r=%0d i=%0d, required 0 0", out_r, out_i); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL reset_sync_err: got %0b, required 0", sync_err); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
        rst_n = 1;
        model_reset();
        repeat (3) begin
            drive(0, 0, 0, 0, 1);
            total++; if (obs_val !== 1'b0) begin bad++; $display("FAIL idle_out_valid: got %0b, required 0", obs_val); end
        end
    endtask

    task automatic test_frame();
        int got[$];
        int ref_r[12];
        exp_t e;
        int j = 0, cyc = 0, tail = 0;
        bit v;
        ref_r = '{S0, S1, S2, S3, DF, DF, DF, DF, 0, 0, 0, 0};
        do_reset();
        clear_stim();
        for (int k = 0; k < 2*D; k++) add_sample(k + 1, 0, k == 0);
        for (int k = 0; k < 2*D; k++) add_sample(0, 0, k == 0);
        while (cyc < LIMIT && (j < stim_r.size() || tail < 4)) begin
            v = (j < stim_r.size());
            if (v) drive(1, stim_s[j], stim_r[j], stim_i[j], 1);
            else begin drive(0, 0, 0, 0, 1); tail++; end
            if (obs_take) begin
                total++;
                got.push_back(obs_r);
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL frame_unexpected: got r=%0d i=%0d, required no output", obs_r, obs_i);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_r !== e.r || obs_i !== e.i || obs_sof !== e.sof) begin
                        bad++; $display("FAIL frame_out: got r=%0d i=%0d sof=%0b, required r=%0d i=%0d sof=%0b", obs_r, obs_i, obs_sof, e.r, e.i, e.sof);
                    end
                end
            end
            if (v && obs_rdy) j++;
            cyc++;
        end
        total++; if (got.size() != 12) begin bad++; $display("FAIL frame_count: got %0d outputs, required 12", got.size()); end
        for (int k = 0; k < 12 && k < got.size(); k++) begin
            total++; if (got[k] !== ref_r[k]) begin bad++; $display("FAIL frame_value[%0d]: got %0d, required %0d", k, got[k], ref_r[k]); end
        end
    endtask

    task automatic test_extremes();
        int got[$];
        exp_t e;
        int j = 0, cyc = 0, tail = 0;
        bit v;
        do_reset();
        clear_stim();
        for (int k = 0; k < 2*D; k++) add_sample(k < D ? -128 : 127, k < D ? -128 : 127, k == 0);
        for (int k = 0; k < 2*D; k++) add_sample(0, 0, k == 0);
        while (cyc < LIMIT && (j < stim_r.size() || tail < 4)) begin
            v = (j < stim_r.size());
            if (v) drive(1, stim_s[j], stim_r[j], stim_i[j], 1);
            else begin drive(0, 0, 0, 0, 1); tail++; end
            if (obs_take) begin
                total++;
                got.push_back(obs_i);
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL ext_unexpected: got r=%0d i=%0d, required no output", obs_r, obs_i);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_r !== e.r || obs_i !== e.i || obs_sof !== e.sof) begin
                        bad++; $display("FAIL ext_out: got r=%0d i=%0d sof=%0b, required r=%0d i=%0d sof=%0b", obs_r, obs_i, obs_sof, e.r, e.i, e.sof);
                    end
                end
            end
            if (v && obs_rdy) j++;
            cyc++;
        end
        total++; if (got.size() < 5 || got[0] !== -1 || got[4] !== XDIF) begin
            bad++; $display("FAIL ext_values: got %0d outputs first=%0d fifth=%0d, required -1 and %0d", got.size(), got.size() > 0 ? got[0] : 0, got.size() > 4 ? got[4] : 0, XDIF);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int j = 0, cyc = 0, tail = 0, hold = 0;
        bit v, ordy;
        do_reset();
        clear_stim();
        for (int k = 0; k < 2*D; k++) add_sample(k + 1, 10 - k, k == 0);
        for (int k = 0; k < 2*D; k++) add_sample(20 - 3*k, k - 4, k == 0);
        for (int k = 0; k < 2*D; k++) add_sample(0, 0, k == 0);
        while (cyc < LIMIT && (j < stim_r.size() || tail < 4)) begin
            v = (j < stim_r.size());
            ordy = !(cyc >= 10 && cyc < 15);
            if (v) drive(1, stim_s[j], stim_r[j], stim_i[j], ordy);
            else begin drive(0, 0, 0, 0, ordy); tail++; end
            if (!ordy) begin
                total++; if (obs_rdy !== 1'b0 || obs_val !== 1'b1) begin bad++; $display("FAIL stall_ready: got in_ready=%0b out_valid=%0b, required 0 1", obs_rdy, obs_val); end
                if (cyc == 10) hold = obs_r;
                else begin
                    total++; if (obs_r !== hold) begin bad++; $display("FAIL stall_hold: got r=%0d, required %0d", obs_r, hold); end
                end
            end
            if (obs_take) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_unexpected: got r=%0d i=%0d, required no output", obs_r, obs_i);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_r !== e.r || obs_i !== e.i || obs_sof !== e.sof) begin
                        bad++; $display("FAIL bp_out: got r=%0d i=%0d sof=%0b, required r=%0d i=%0d sof=%0b", obs_r, obs_i, obs_sof, e.r, e.i, e.sof);
                    end
                end
            end
            if (v && obs_rdy) j++;
            cyc++;
        end
        total++; if (exp_q.size() != 0 || j != stim_r.size()) begin bad++; $display("FAIL bp_drain: got %0d pending %0d sent, required 0 pending %0d sent", exp_q.size(), j, stim_r.size()); end
    endtask

    task automatic test_resync();
        int got[$];
        exp_t e;
        int j = 0, cyc = 0, tail = 0;
        bit v;
        do_reset();
        clear_stim();
        add_sample(7, 1, 1);
        add_sample(9, 2, 0);
        for (int k = 0; k < 2*D; k++) add_sample(k + 1, 0, k == 0);
        for (int k = 0; k < 2*D; k++) add_sample(0, 0, k == 0);
        while (cyc < LIMIT && (j < stim_r.size() || tail < 4)) begin
            v = (j < stim_r.size());
            if (v) drive(1, stim_s[j], stim_r[j], stim_i[j], 1);
            else begin drive(0, 0, 0, 0, 1); tail++; end
            if (obs_take) begin
                total++;
                got.push_back(obs_r);
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL resync_unexpected: got r=%0d i=%0d, required no output", obs_r, obs_i);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_r !== e.r || obs_i !== e.i || obs_sof !== e.sof) begin
                        bad++; $display("FAIL resync_out: got r=%0d i=%0d sof=%0b, required r=%0d i=%0d sof=%0b", obs_r, obs_i, obs_sof, e.r, e.i, e.sof);
                    end
                end
            end
            if (v && obs_rdy) j++;
            cyc++;
        end
        total++; if (sync_err !== 1'b1 || !exp_sync) begin bad++; $display("FAIL resync_flag: got %0b, required 1", sync_err); end
        total++; if (got.size() < 4 || got[0] !== S0 || got[3] !== S3) begin
            bad++; $display("FAIL resync_sums: got %0d outputs first=%0d, required first=%0d fourth=%0d", got.size(), got.size() > 0 ? got[0] : 0, S0, S3);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int j = 0, cyc = 0, tail = 0;
        bit v, ordy;
        do_reset();
        clear_stim();
        for (int f = 0; f < 5; f++)
            for (int k = 0; k < 2*D; k++)
                add_sample(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, k == 0);
        for (int k = 0; k < 2*D; k++) add_sample(0, 0, k == 0);
        while (cyc < LIMIT && (j < stim_r.size() || tail < 6)) begin
            v = (j < stim_r.size()) && ($urandom_range(3) != 0);
            ordy = ($urandom_range(3) != 0) || (j >= stim_r.size());
            if (v) drive(1, stim_s[j], stim_r[j], stim_i[j], ordy);
            else begin drive(0, 0, 0, 0, ordy); if (j >= stim_r.size()) tail++; end
            if (obs_take) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_unexpected: got r=%0d i=%0d, required no output", obs_r, obs_i);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_r !== e.r || obs_i !== e.i || obs_sof !== e.sof) begin
                        bad++; $display("FAIL rand_out: got r=%0d i=%0d sof=%0b, required r=%0d i=%0d sof=%0b", obs_r, obs_i, obs_sof, e.r, e.i, e.sof);
                    end
                end
            end
            if (v && obs_rdy) j++;
            cyc++;
        end
        total++; if (exp_q.size() != 0 || j != stim_r.size()) begin bad++; $display("FAIL rand_drain: got %0d pending %0d sent, required 0 pending %0d sent", exp_q.size(), j, stim_r.size()); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rand_sync_err: got %0b, required 0", sync_err); end
    endtask

    task automatic test_midreset();
        exp_t e;
        int j = 0, cyc = 0, tail = 0;
        bit v;
        do_reset();
        for (int k = 0; k < 2*D + 3; k++) drive(1, k == 0, 50 + k, -k, 1);
        #2 rst_n = 0;
        #2 rst_n = 1;
        model_reset();
        total++; if (out_valid !== 1'b0 || sync_err !== 1'b0) begin bad++; $display("FAIL midreset_clear: got out_valid=%0b sync_err=%0b, required 0 0", out_valid, sync_err); end
        clear_stim();
        for (int k = 0; k < 2*D; k++) add_sample(k + 1, 0, k == 0);
        for (int k = 0; k < 2*D; k++) add_sample(0, 0, k == 0);
        while (cyc < LIMIT && (j < stim_r.size() || tail < 4)) begin
            v = (j < stim_r.size());
            if (v) drive(1, stim_s[j], stim_r[j], stim_i[j], 1);
            else begin drive(0, 0, 0, 0, 1); tail++; end
            if (obs_take) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL midreset_unexpected: got r=%0d i=%0d, required no output", obs_r, obs_i);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_r !== e.r || obs_i !== e.i || obs_sof !== e.sof) begin
                        bad++; $display("FAIL midreset_out: got r=%0d i=%0d sof=%0b, required r=%0d i=%0d sof=%0b", obs_r, obs_i, obs_sof, e.r, e.i, e.sof);
                    end
                end
            end
            if (v && obs_rdy) j++;
            cyc++;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL midreset_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_extremes();
        test_backpressure();
        test_resync();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
